audio_adc: RTL and testbench

AUDIO_ADC -- requirements
Module: audio_adc

---
 rtl/audio_adc.sv | 220 ++++++++++++++++++++++
 tb/tb_audio_adc.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/audio_adc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : audio_adc                                                  |
// | Description : Delta-sigma audio ADC back end. An external comparator and |
// |               RC integrator form the 1-bit modulator. This block         |
// |               synchronizes the comparator bit, returns it as feedback    |
// |               and decimates the bitstream with a 2nd-order CIC (sinc2)   |
// |               filter into unsigned WIDTH-bit samples. Samples are        |
// |               offered on a valid/ready handshake with a sticky overrun   |
// |               flag.                                                      |
// |                                                                          |
// | Ports       : clk             - single clock, rising edge                |
// |               reset_i         - asynchronous active-high reset           |
// |               enable_i        - conversion enable                        |
// |               cmp_i           - comparator output (async to clk)         |
// |               fb_o            - 1-bit feedback to the RC integrator      |
// |               sample_o        - decimated unsigned sample                |
// |               sample_valid_o  - sample_o holds an unconsumed sample      |
// |               sample_ready_i  - consumer accepts the sample              |
// |               overrun_o       - sticky: a sample was overwritten         |
// |               clear_overrun_i - synchronous clear of overrun_o           |
// |                                                                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module audio_adc #(
  parameter int WIDTH      = 8,
  parameter int DECIM_LOG2 = 8
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             cmp_i,
  output logic             fb_o,
  output logic [WIDTH-1:0] sample_o,
  output logic             sample_valid_o,
  input  logic             sample_ready_i,
  output logic             overrun_o,
  input  logic             clear_overrun_i
);

  // Integrator / comb width. The sinc2 output spans 0..R^2, which needs
  // 2*DECIM_LOG2+1 bits; modulo arithmetic in the integrators is exact as
  // long as the combs use the same width.
  localparam int IW    = 2 * DECIM_LOG2 + 1;
  // Number of comb LSBs below the selected output field.
  localparam int SHIFT = 2 * DECIM_LOG2 - WIDTH;

  localparam logic [DECIM_LOG2-1:0] CNT_MAX   = {DECIM_LOG2{1'b1}};
  // Warm-up: two comb outputs are discarded, the third wrap loads a sample.
  localparam logic [1:0]            WARM_DONE = 2'd2;

  // --------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------
  logic                  sync1_q,     sync1_d;
  logic                  sync2_q,     sync2_d;
  logic                  fb_q,        fb_d;
  logic [IW-1:0]         int1_q,      int1_d;
  logic [IW-1:0]         int2_q,      int2_d;
  logic [DECIM_LOG2-1:0] cnt_q,       cnt_d;
  logic [IW-1:0]         dly1_q,      dly1_d;
  logic [IW-1:0]         dly2_q,      dly2_d;
  logic [IW-1:0]         comb_q,      comb_d;
  logic [1:0]            warm_q,      warm_d;
  logic                  load_pend_q, load_pend_d;
  logic [WIDTH-1:0]      sample_q,    sample_d;
  logic                  valid_q,     valid_d;
  logic                  overrun_q,   overrun_d;

  // --------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------
  logic             w_bit;
  logic             w_wrap;
  logic             w_load;
  logic             w_overwrite;
  logic [IW-1:0]    w_c1;
  logic [IW-1:0]    w_c2;
  logic [WIDTH-1:0] w_result;

  // Modulator bit is the output of the second synchronizer flop.
  assign w_bit  = sync2_q;
  assign w_wrap = enable_i && (cnt_q == CNT_MAX);

  // Comb stages evaluated against the previous decimated-rate values.
  assign w_c1 = int2_q - dly1_q;
  assign w_c2 = w_c1 - dly2_q;

  // A pending load is dropped if enable falls on the edge it would occur.
  assign w_load      = enable_i && load_pend_q;
  assign w_overwrite = w_load && valid_q && !sample_ready_i;

  // Full-scale input gives exactly R^2, whose only set bit is the MSB;
  // clamp it to all ones instead of wrapping to zero.
  always_comb begin
    w_result = comb_q[2*DECIM_LOG2-1 -: WIDTH];
    if (comb_q[2*DECIM_LOG2]) begin
      w_result = {WIDTH{1'b1}};
    end
  end

  // Comb LSBs below the output field only matter through the subtraction
  // borrows, so they are never read directly.
  generate
    if (SHIFT > 0) begin : g_comb_lsb_sink
      logic unused_comb_lsbs;
      assign unused_comb_lsbs = ^comb_q[SHIFT-1:0];
    end
  endgenerate

  // --------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------
  always_comb begin
    // Synchronizer and feedback run regardless of enable.
    sync1_d     = cmp_i;
    sync2_d     = sync1_q;
    fb_d        = sync2_q;

    int1_d      = int1_q;
    int2_d      = int2_q;
    cnt_d       = cnt_q;
    dly1_d      = dly1_q;
    dly2_d      = dly2_q;
    comb_d      = comb_q;
    warm_d      = warm_q;
    load_pend_d = 1'b0;
    sample_d    = sample_q;
    valid_d     = valid_q;

    if (!enable_i) begin
      // Disabled: flush the filter and warm-up so the next enable starts
      // from a clean state; the last sample stays visible on sample_o.
      int1_d  = '0;
      int2_d  = '0;
      cnt_d   = '0;
      dly1_d  = '0;
      dly2_d  = '0;
      comb_d  = '0;
      warm_d  = '0;
      valid_d = 1'b0;
    end else begin
      int1_d = int1_q + {{(IW-1){1'b0}}, w_bit};
      int2_d = int2_q + int1_q;
      // Natural DECIM_LOG2-bit wrap gives R-1 -> 0.
      cnt_d  = cnt_q + 1'b1;

      if (w_wrap) begin
        dly1_d = int2_q;
        dly2_d = w_c1;
        comb_d = w_c2;
        if (warm_q == WARM_DONE) begin
          load_pend_d = 1'b1;
        end else begin
          warm_d = warm_q + 2'd1;
        end
      end

      if (w_load) begin
        sample_d = w_result;
        valid_d  = 1'b1;
      end else if (valid_q && sample_ready_i) begin
        valid_d  = 1'b0;
      end
    end

    // Sticky overrun: an overwrite of an unaccepted sample beats a clear.
    overrun_d = overrun_q;
    if (w_overwrite) begin
      overrun_d = 1'b1;
    end else if (clear_overrun_i) begin
      overrun_d = 1'b0;
    end
  end

  // --------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      fb_q        <= 1'b0;
      int1_q      <= '0;
      int2_q      <= '0;
      cnt_q       <= '0;
      dly1_q      <= '0;
      dly2_q      <= '0;
      comb_q      <= '0;
      warm_q      <= '0;
      load_pend_q <= 1'b0;
      sample_q    <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      fb_q        <= fb_d;
      int1_q      <= int1_d;
      int2_q      <= int2_d;
      cnt_q       <= cnt_d;
      dly1_q      <= dly1_d;
      dly2_q      <= dly2_d;
      comb_q      <= comb_d;
      warm_q      <= warm_d;
      load_pend_q <= load_pend_d;
      sample_q    <= sample_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  // All outputs come straight from flops; valid has no path from ready.
  assign fb_o           = fb_q;
  assign sample_o       = sample_q;
  assign sample_valid_o = valid_q;
  assign overrun_o      = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_adc.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_audio_adc                                               |
// | Description : Directed self-checking bench for audio_adc with WIDTH=8,   |
// |               DECIM_LOG2=8 (R=256). Inputs change and outputs are        |
// |               sampled on the falling clock edge.                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_audio_adc;

  localparam int WIDTH      = 8;
  localparam int DECIM_LOG2 = 8;
  localparam int R          = 256;
  // Enabled edges are numbered from 1. Wraps land on edges 256, 512, 768;
  // the first load is one edge after the third wrap.
  localparam int FIRST_LAT  = 3 * R + 1;

  logic             clk = 1'b0;
  logic             reset_i = 1'b0;
  logic             enable_i = 1'b0;
  logic             cmp_i = 1'b0;
  logic             fb_o;
  logic [WIDTH-1:0] sample_o;
  logic             sample_valid_o;
  logic             sample_ready_i = 1'b0;
  logic             overrun_o;
  logic             clear_overrun_i = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  audio_adc #(
    .WIDTH      (WIDTH),
    .DECIM_LOG2 (DECIM_LOG2)
  ) dut (
    .clk             (clk),
    .reset_i         (reset_i),
    .enable_i        (enable_i),
    .cmp_i           (cmp_i),
    .fb_o            (fb_o),
    .sample_o        (sample_o),
    .sample_valid_o  (sample_valid_o),
    .sample_ready_i  (sample_ready_i),
    .overrun_o       (overrun_o),
    .clear_overrun_i (clear_overrun_i)
  );

  // Counts falling edges until sample_valid_o is seen; returns limit+1 when
  // the budget expires so the caller's comparison fails.
  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (sample_valid_o !== 1'b1 && n <= limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    #1 reset_i = 1'b1;
    #2;
    tests_run++; if (fb_o !== 1'b0) begin tests_failed++; $display("FAIL reset_fb: got %b want 0", fb_o); end
    tests_run++; if (sample_o !== 8'h00) begin tests_failed++; $display("FAIL reset_sample: got %h want 00", sample_o); end
    tests_run++; if (sample_valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", sample_valid_o); end
    tests_run++; if (overrun_o !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun: got %b want 0", overrun_o); end
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
  endtask

  task automatic test_zero_input;
    int n;
    cmp_i = 1'b0; sample_ready_i = 1'b1;
    @(negedge clk);
    enable_i = 1'b1;
    wait_valid(2000, n);
    tests_run++; if (n !== FIRST_LAT) begin tests_failed++; $display("FAIL zero_first_latency: got %0d want %0d", n, FIRST_LAT); end
    tests_run++; if (sample_o !== 8'h00) begin tests_failed++; $display("FAIL zero_sample1: got %h want 00", sample_o); end
    @(negedge clk);
    tests_run++; if (sample_valid_o !== 1'b0) begin tests_failed++; $display("FAIL zero_accept: got %b want 0", sample_valid_o); end
    wait_valid(400, n);
    tests_run++; if (n !== R - 1) begin tests_failed++; $display("FAIL zero_period: got %0d want %0d", n, R - 1); end
    tests_run++; if (sample_o !== 8'h00) begin tests_failed++; $display("FAIL zero_sample2: got %h want 00", sample_o); end
  endtask

  task automatic test_full_scale;
    int n;
    enable_i = 1'b0; cmp_i = 1'b1;
    repeat (4) @(negedge clk);
    enable_i = 1'b1;
    wait_valid(2000, n);
    tests_run++; if (n !== FIRST_LAT) begin tests_failed++; $display("FAIL full_first_latency: got %0d want %0d", n, FIRST_LAT); end
    tests_run++; if (sample_o !== 8'hFF) begin tests_failed++; $display("FAIL full_sample1: got %h want ff", sample_o); end
    @(negedge clk);
    wait_valid(400, n);
    tests_run++; if (n !== R - 1) begin tests_failed++; $display("FAIL full_period: got %0d want %0d", n, R - 1); end
    tests_run++; if (sample_o !== 8'hFF) begin tests_failed++; $display("FAIL full_sample2: got %h want ff", sample_o); end
  endtask

  // cmp_i toggles every clock; fb_o after edge m must equal cmp_i sampled
  // at edge m-2 (three-flop path from the pin).
  task automatic test_alternating;
    logic p0, p1, p2;
    int   hist, fb_err, samples;
    p0 = 1'b0; p1 = 1'b0; p2 = 1'b0;
    hist = 0; fb_err = 0; samples = 0;
    enable_i = 1'b0; sample_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      p2 = p1; p1 = p0; p0 = cmp_i; hist++;
      if (hist > 3 && fb_o !== p2) fb_err++;
      cmp_i = ~cmp_i;
    end
    enable_i = 1'b1;
    for (int i = 0; i < 2000 && samples < 3; i++) begin
      @(negedge clk);
      p2 = p1; p1 = p0; p0 = cmp_i; hist++;
      if (fb_o !== p2) fb_err++;
      if (sample_valid_o === 1'b1) begin
        samples++;
        tests_run++; if (sample_o !== 8'h80) begin tests_failed++; $display("FAIL alt_sample%0d: got %h want 80", samples, sample_o); end
      end
      cmp_i = ~cmp_i;
    end
    tests_run++; if (samples !== 3) begin tests_failed++; $display("FAIL alt_sample_count: got %0d want 3", samples); end
    tests_run++; if (fb_err !== 0) begin tests_failed++; $display("FAIL alt_fb_delay: got %0d errors want 0", fb_err); end
  endtask

  // Consumer stalls for three periods; input switches to full scale after
  // the first sample so the latest sample (edge 1537) reads ff.
  task automatic test_overrun;
    int n, vdrop;
    enable_i = 1'b0; cmp_i = 1'b0; sample_ready_i = 1'b0; clear_overrun_i = 1'b0;
    repeat (2) @(negedge clk);
    enable_i = 1'b1;
    wait_valid(2000, n);
    tests_run++; if (n !== FIRST_LAT) begin tests_failed++; $display("FAIL ovr_first_latency: got %0d want %0d", n, FIRST_LAT); end
    tests_run++; if (overrun_o !== 1'b0) begin tests_failed++; $display("FAIL ovr_initial: got %b want 0", overrun_o); end
    cmp_i = 1'b1;
    vdrop = 0;
    repeat (3 * R) begin
      @(negedge clk);
      if (sample_valid_o !== 1'b1) vdrop++;
    end
    tests_run++; if (vdrop !== 0) begin tests_failed++; $display("FAIL ovr_valid_held: got %0d drops want 0", vdrop); end
    tests_run++; if (overrun_o !== 1'b1) begin tests_failed++; $display("FAIL ovr_set: got %b want 1", overrun_o); end
    tests_run++; if (sample_o !== 8'hFF) begin tests_failed++; $display("FAIL ovr_latest: got %h want ff", sample_o); end
  endtask

  // Continues from the negedge after edge 1537; next loads at 1793, 2049.
  task automatic test_clear_overrun;
    clear_overrun_i = 1'b1;
    @(negedge clk);
    clear_overrun_i = 1'b0;
    tests_run++; if (overrun_o !== 1'b0) begin tests_failed++; $display("FAIL clr_plain: got %b want 0", overrun_o); end
    repeat (R - 2) @(negedge clk);
    clear_overrun_i = 1'b1;
    @(negedge clk);
    clear_overrun_i = 1'b0;
    tests_run++; if (overrun_o !== 1'b1) begin tests_failed++; $display("FAIL clr_set_wins: got %b want 1", overrun_o); end
    clear_overrun_i = 1'b1;
    @(negedge clk);
    clear_overrun_i = 1'b0;
    tests_run++; if (overrun_o !== 1'b0) begin tests_failed++; $display("FAIL clr_again: got %b want 0", overrun_o); end
    repeat (R - 2) @(negedge clk);
    sample_ready_i = 1'b1;
    @(negedge clk);
    tests_run++; if (sample_valid_o !== 1'b1) begin tests_failed++; $display("FAIL coinc_valid: got %b want 1", sample_valid_o); end
    tests_run++; if (overrun_o !== 1'b0) begin tests_failed++; $display("FAIL coinc_overrun: got %b want 0", overrun_o); end
    @(negedge clk);
    tests_run++; if (sample_valid_o !== 1'b0) begin tests_failed++; $display("FAIL coinc_accept: got %b want 0", sample_valid_o); end
  endtask

  task automatic test_reset_mid_period;
    int n;
    sample_ready_i = 1'b0;
    wait_valid(400, n);
    tests_run++; if (n !== R - 1) begin tests_failed++; $display("FAIL rst_pre_valid: got %0d want %0d", n, R - 1); end
    repeat (100) @(negedge clk);
    #2 reset_i = 1'b1;
    #1;
    tests_run++; if ({fb_o, sample_valid_o, overrun_o} !== 3'b000) begin tests_failed++; $display("FAIL rst_async_flags: got %b want 000", {fb_o, sample_valid_o, overrun_o}); end
    tests_run++; if (sample_o !== 8'h00) begin tests_failed++; $display("FAIL rst_async_sample: got %h want 00", sample_o); end
    @(negedge clk);
    reset_i = 1'b0;
    wait_valid(2000, n);
    tests_run++; if (n !== FIRST_LAT) begin tests_failed++; $display("FAIL rst_warmup: got %0d want %0d", n, FIRST_LAT); end
    tests_run++; if (sample_o !== 8'hFF) begin tests_failed++; $display("FAIL rst_sample: got %h want ff", sample_o); end
  endtask

  task automatic test_enable_drop;
    int n;
    enable_i = 1'b0; cmp_i = 1'b0;
    @(negedge clk);
    tests_run++; if (sample_valid_o !== 1'b0) begin tests_failed++; $display("FAIL dis_valid: got %b want 0", sample_valid_o); end
    repeat (9) @(negedge clk);
    tests_run++; if (sample_o !== 8'hFF) begin tests_failed++; $display("FAIL dis_sample_held: got %h want ff", sample_o); end
    tests_run++; if (fb_o !== 1'b0) begin tests_failed++; $display("FAIL dis_fb_running: got %b want 0", fb_o); end
    enable_i = 1'b1;
    wait_valid(2000, n);
    tests_run++; if (n !== FIRST_LAT) begin tests_failed++; $display("FAIL dis_warmup: got %0d want %0d", n, FIRST_LAT); end
    tests_run++; if (sample_o !== 8'h00) begin tests_failed++; $display("FAIL dis_new_sample: got %h want 00", sample_o); end
  endtask

  initial begin
    test_reset;
    test_zero_input;
    test_full_scale;
    test_alternating;
    test_overrun;
    test_clear_overrun;
    test_reset_mid_period;
    test_enable_drop;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d of %0d failed so far", tests_failed, tests_run);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
